// File: rtl/dp_pkg.sv
// Shared definitions for the pipelined regfile + ALU datapath.
package dp_pkg;

  localparam int DEFAULT_XLEN = 32;

  // ALU operation codes driven on alu_control
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_MUL  = 4'b1100;

endpackage

// File: rtl/dp_regfile.sv
// Architectural register file: two combinational read ports, one write port.
// Entry 0 is a constant zero; every other entry is cleared by reset.
module dp_regfile
  import dp_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [NREGS-1:0][XLEN-1:0] rf_q;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_entry
      if (gi == 0) begin : g_zero
        assign rf_q[gi] = '0;
      end else begin : g_reg
        logic [XLEN-1:0] entry_reg;
        // One storage word; loads when the write port targets this index
        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            entry_reg <= '0;
          end else if (we && (waddr == AW'(gi))) begin
            entry_reg <= wdata;
          end
        end
        assign rf_q[gi] = entry_reg;
      end
    end
  endgenerate

  assign rdata1 = rf_q[raddr1];
  assign rdata2 = rf_q[raddr2];

endmodule

// File: rtl/pipelined_datapath.sv
// Two-stage issue/execute datapath: regfile read and operand capture on issue,
// then ALU execute and writeback. MUL runs as an XLEN-step shift-add loop in
// the EX stage and holds off issue while it iterates.
module pipelined_datapath
  import dp_pkg::*;
#(
  parameter int XLEN   = DEFAULT_XLEN,
  parameter int NREGS  = 32,
  parameter int MUL_EN = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [3:0]      alu_control,
  input  logic            use_imm,
  input  logic [XLEN-1:0] imm,
  input  logic            regwrite,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic            zero_flag,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);

  // EX stage state
  logic            ex_valid_reg;
  logic [3:0]      ex_op_reg;
  logic [XLEN-1:0] ex_a_reg;
  logic [XLEN-1:0] ex_b_reg;
  logic [AW-1:0]   ex_rd_reg;
  logic            ex_we_reg;
  logic [CW-1:0]   mul_cnt_reg;
  logic [XLEN-1:0] mul_acc_reg;

  // Completion outputs
  logic            out_valid_reg;
  logic [XLEN-1:0] out_result_reg;
  logic            zero_flag_reg;

  logic            ex_is_mul;
  logic            mul_busy;
  logic            ex_done;
  logic            accept;
  logic            rf_we;
  logic            fwd1;
  logic            fwd2;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] ex_result;
  logic [SW-1:0]   shamt;

  // A MUL is iterative only when the multiplier is built in; otherwise it
  // falls through the ALU case and yields 0 in one cycle.
  assign ex_is_mul = (MUL_EN != 0) && (ex_op_reg == ALU_MUL);
  assign mul_busy  = ex_valid_reg && ex_is_mul && (mul_cnt_reg != CW'(XLEN));
  assign ex_done   = ex_valid_reg && !mul_busy;
  assign accept    = in_valid && !mul_busy;
  assign in_ready  = !mul_busy;
  assign busy      = mul_busy;

  assign rf_we = ex_done && ex_we_reg && (ex_rd_reg != '0);

  dp_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clock  (clock),
    .reset  (reset),
    .raddr1 (rs1),
    .rdata1 (rdata1),
    .raddr2 (rs2),
    .rdata2 (rdata2),
    .we     (rf_we),
    .waddr  (ex_rd_reg),
    .wdata  (ex_result)
  );

  // Bypass: the result retiring at the coming edge is not yet in the regfile,
  // so a dependent op issued on that same edge takes it directly.
  assign fwd1 = rf_we && (rs1 == ex_rd_reg);
  assign fwd2 = rf_we && (rs2 == ex_rd_reg);
  assign op_a = fwd1 ? ex_result : rdata1;
  assign op_b = use_imm ? imm : (fwd2 ? ex_result : rdata2);

  assign shamt = ex_b_reg[SW-1:0];

  // ALU: combinational result of the op currently held in EX
  always_comb begin
    ex_result = '0;
    case (ex_op_reg)
      ALU_AND:  ex_result = ex_a_reg & ex_b_reg;
      ALU_OR:   ex_result = ex_a_reg | ex_b_reg;
      ALU_ADD:  ex_result = ex_a_reg + ex_b_reg;
      ALU_XOR:  ex_result = ex_a_reg ^ ex_b_reg;
      ALU_SUB:  ex_result = ex_a_reg - ex_b_reg;
      ALU_SLT:  ex_result = {{(XLEN-1){1'b0}}, ($signed(ex_a_reg) < $signed(ex_b_reg))};
      ALU_SLL:  ex_result = ex_a_reg << shamt;
      ALU_SRL:  ex_result = ex_a_reg >> shamt;
      ALU_SRA:  ex_result = $signed(ex_a_reg) >>> shamt;
      ALU_SLTU: ex_result = {{(XLEN-1){1'b0}}, (ex_a_reg < ex_b_reg)};
      ALU_MUL:  ex_result = (MUL_EN != 0) ? mul_acc_reg : '0;
      default:  ex_result = '0;
    endcase
  end

  // EX register: capture on issue, retire on completion, otherwise step the
  // multiplier (operand A shifts left as multiplicand, B right as multiplier)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_valid_reg <= 1'b0;
      ex_op_reg    <= '0;
      ex_a_reg     <= '0;
      ex_b_reg     <= '0;
      ex_rd_reg    <= '0;
      ex_we_reg    <= 1'b0;
      mul_cnt_reg  <= '0;
      mul_acc_reg  <= '0;
    end else if (accept) begin
      ex_valid_reg <= 1'b1;
      ex_op_reg    <= alu_control;
      ex_a_reg     <= op_a;
      ex_b_reg     <= op_b;
      ex_rd_reg    <= rd;
      ex_we_reg    <= regwrite;
      mul_cnt_reg  <= '0;
      mul_acc_reg  <= '0;
    end else if (ex_done) begin
      ex_valid_reg <= 1'b0;
    end else if (mul_busy) begin
      if (ex_b_reg[0]) begin
        mul_acc_reg <= mul_acc_reg + ex_a_reg;
      end
      ex_a_reg    <= ex_a_reg << 1;
      ex_b_reg    <= ex_b_reg >> 1;
      mul_cnt_reg <= mul_cnt_reg + CW'(1);
    end
  end

  // Completion report: one-cycle valid pulse, result and zero flag held between ops
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
      zero_flag_reg  <= 1'b0;
    end else begin
      out_valid_reg <= ex_done;
      if (ex_done) begin
        out_result_reg <= ex_result;
        zero_flag_reg  <= (ex_result == '0);
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
  assign zero_flag  = zero_flag_reg;

endmodule
